// File: rtl/bitblade_pkg.sv
// rtl/bitblade_pkg.sv - shared types, brick constants and shift helper for the BitBlade serial MAC
//   state_t      : FSM states of the serial MAC
//   BRICK_W      : width of one operand brick
//   BRICK_PROD_W : width of one signed brick product
//   brick_shift  : left shift applied to the product of brick pair (i, j)
package bitblade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BRICK_W      = 2;
  localparam int BRICK_PROD_W = 6;

  // Brick i of a carries weight 2^(2i), brick j of b carries 2^(2j).
  function automatic int unsigned brick_shift(input int unsigned i, input int unsigned j);
    return BRICK_W * (i + j);
  endfunction

endpackage

// File: rtl/bitblade_brick_mul_2x2.sv
// rtl/bitblade_brick_mul_2x2.sv - combinational 2x2 brick multiplier with per-operand sign flags
//   a, b     : 2-bit bricks
//   sign_a   : treat brick a as the signed top brick (bit 1 has negative weight)
//   sign_b   : same for brick b
//   prod     : 6-bit signed product of the 3-bit extended bricks
module bitblade_brick_mul_2x2
  import bitblade_pkg::*;
(
  input  logic [BRICK_W-1:0]             a,
  input  logic [BRICK_W-1:0]             b,
  input  logic                           sign_a,
  input  logic                           sign_b,
  output logic signed [BRICK_PROD_W-1:0] prod
);

  localparam int XW = BRICK_W + 1;

  logic [XW-1:0] ax;
  logic [XW-1:0] bx;

  assign ax = {sign_a & a[BRICK_W-1], a};
  assign bx = {sign_b & b[BRICK_W-1], b};

  // Baugh-Wooley partial products: the extension bit of each operand has
  // negative weight, so a partial product that involves exactly one
  // extension bit is subtracted; one with both (or neither) is added.
  // The true result fits in 6 signed bits, so modulo-64 arithmetic is exact.
  always_comb begin
    prod = '0;
    for (int i = 0; i < XW; i++) begin
      for (int j = 0; j < XW; j++) begin
        if (ax[i] & bx[j]) begin
          if ((i == XW - 1) != (j == XW - 1))
            prod = prod - (BRICK_PROD_W'(1) << (i + j));
          else
            prod = prod + (BRICK_PROD_W'(1) << (i + j));
        end
      end
    end
  end

endmodule

// File: rtl/bitblade_serial_mac.sv
// rtl/bitblade_serial_mac.sv - brick-serial precision-scalable signed/unsigned multiply-accumulate
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_ready : operand handshake
//   a, b               : operands, low 2*(prec+1) bits active
//   sign_i, sign_w     : a / b are two's-complement
//   prec_a, prec_b     : active bricks minus one
//   acc_clr            : zero acc at the handshake
//   acc                : two's-complement accumulator
//   out_valid          : one-cycle pulse when acc holds the finished product
//   busy               : brick pairs are being processed
module bitblade_serial_mac
  import bitblade_pkg::*;
#(
  parameter  int MAX_BITS = 8,
  parameter  int ACC_W    = 32,
  localparam int NBR      = MAX_BITS / 2,
  localparam int PREC_W   = (NBR > 1) ? $clog2(NBR) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_BITS-1:0] a,
  input  logic [MAX_BITS-1:0] b,
  input  logic                sign_i,
  input  logic                sign_w,
  input  logic [PREC_W-1:0]   prec_a,
  input  logic [PREC_W-1:0]   prec_b,
  input  logic                acc_clr,
  output logic [ACC_W-1:0]    acc,
  output logic                out_valid,
  output logic                busy
);

  localparam logic [PREC_W:0] LAST_IDX = (PREC_W + 1)'(NBR - 1);

  state_t                          state;
  logic [MAX_BITS-1:0]             a_reg;
  logic [MAX_BITS-1:0]             b_reg;
  logic                            sign_i_reg;
  logic                            sign_w_reg;
  logic [PREC_W-1:0]               na_m1;
  logic [PREC_W-1:0]               nb_m1;
  logic [PREC_W-1:0]               i_cnt;
  logic [PREC_W-1:0]               j_cnt;

  logic [PREC_W-1:0]               prec_a_cl;
  logic [PREC_W-1:0]               prec_b_cl;
  logic                            i_last;
  logic                            j_last;
  logic [BRICK_W-1:0]              a_brick;
  logic [BRICK_W-1:0]              b_brick;
  logic signed [BRICK_PROD_W-1:0]  brick_prod;
  logic [ACC_W-1:0]                prod_ext;
  logic [ACC_W-1:0]                addend;

  // Widen by one bit before comparing so the clamp stays meaningful when
  // NBR is not a power of two (and is simply never taken when it is).
  assign prec_a_cl = ({1'b0, prec_a} > LAST_IDX) ? LAST_IDX[PREC_W-1:0] : prec_a;
  assign prec_b_cl = ({1'b0, prec_b} > LAST_IDX) ? LAST_IDX[PREC_W-1:0] : prec_b;

  assign i_last  = (i_cnt == na_m1);
  assign j_last  = (j_cnt == nb_m1);

  // Bricks above the active width are never selected, so their bits are ignored.
  assign a_brick = a_reg[{i_cnt, 1'b0} +: BRICK_W];
  assign b_brick = b_reg[{j_cnt, 1'b0} +: BRICK_W];

  bitblade_brick_mul_2x2 u_brick_mul (
    .a      (a_brick),
    .b      (b_brick),
    .sign_a (sign_i_reg & i_last),
    .sign_b (sign_w_reg & j_last),
    .prod   (brick_prod)
  );

  assign prod_ext = {{(ACC_W - BRICK_PROD_W){brick_prod[BRICK_PROD_W-1]}}, brick_prod};
  assign addend   = prod_ext << brick_shift(32'(i_cnt), 32'(j_cnt));

  assign in_ready = (state != RUN);
  assign busy     = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      out_valid  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      sign_i_reg <= 1'b0;
      sign_w_reg <= 1'b0;
      na_m1      <= '0;
      nb_m1      <= '0;
      i_cnt      <= '0;
      j_cnt      <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts too, so back-to-back ops lose no cycle.
          if (in_valid) begin
            a_reg      <= a;
            b_reg      <= b;
            sign_i_reg <= sign_i;
            sign_w_reg <= sign_w;
            na_m1      <= prec_a_cl;
            nb_m1      <= prec_b_cl;
            i_cnt      <= '0;
            j_cnt      <= '0;
            if (acc_clr)
              acc <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc + addend;
          if (i_last) begin
            i_cnt <= '0;
            if (j_last) begin
              j_cnt     <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              j_cnt <= j_cnt + 1'b1;
            end
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitblade_serial_mac.sv
// tb/tb_bitblade_serial_mac.sv - scoreboard testbench for bitblade_serial_mac
module tb_bitblade_serial_mac;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_valid16;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sign_i;
  logic        sign_w;
  logic [1:0]  prec_a;
  logic [1:0]  prec_b;
  logic        acc_clr;

  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [31:0] acc;
  logic        in_ready16;
  logic        busy16;
  logic        out_valid16;
  logic [15:0] acc16;

  int          errors;
  int          checks;
  longint      model_acc;
  longint      model16;
  logic [31:0] q[$];

  bitblade_serial_mac #(.MAX_BITS(8), .ACC_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sign_i    (sign_i),
    .sign_w    (sign_w),
    .prec_a    (prec_a),
    .prec_b    (prec_b),
    .acc_clr   (acc_clr),
    .acc       (acc),
    .out_valid (out_valid),
    .busy      (busy)
  );

  bitblade_serial_mac #(.MAX_BITS(8), .ACC_W(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a),
    .b         (b),
    .sign_i    (sign_i),
    .sign_w    (sign_w),
    .prec_a    (prec_a),
    .prec_b    (prec_b),
    .acc_clr   (acc_clr),
    .acc       (acc16),
    .out_valid (out_valid16),
    .busy      (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer value of the active low 2*(p+1) bits of x.
  function automatic longint opval(input logic [7:0] x, input logic s, input logic [1:0] p);
    int     n;
    longint v;
    n = 2 * (int'(p) + 1);
    v = 0;
    for (int k = 0; k < n; k++)
      if (x[k]) v = v + (longint'(1) << k);
    if (s && x[n-1]) v = v - (longint'(1) << n);
    return v;
  endfunction

  // Drive one operand pair (called just after a negedge while the DUT can
  // accept), record the expected accumulator, and release in_valid after the
  // handshake edge.
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic si,
                        input logic sw, input logic [1:0] pa, input logic [1:0] pb,
                        input logic clr, input bit use16, input bit push);
    longint p;
    p       = opval(ta, si, pa) * opval(tb_v, sw, pb);
    a       = ta;
    b       = tb_v;
    sign_i  = si;
    sign_w  = sw;
    prec_a  = pa;
    prec_b  = pb;
    acc_clr = clr;
    if (use16) begin
      if (clr) model16 = 0;
      model16 = model16 + p;
      if (push) q.push_back({16'h0, model16[15:0]});
      in_valid16 = 1'b1;
    end else begin
      if (clr) model_acc = 0;
      model_acc = model_acc + p;
      if (push) q.push_back(model_acc[31:0]);
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_valid16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (acc !== 32'd0) begin errors++; $display("FAIL reset_acc got=%h want=%h", acc, 32'd0); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_unsigned_2b();
    int lat;
    logic [31:0] exp_v;
    launch(8'd3, 8'd3, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin lat = c; break; end
    end
    exp_v = q.pop_front();
    checks++; if (lat != 2) begin errors++; $display("FAIL u2b_latency got=%0d want=2", lat); end
    checks++; if (acc !== exp_v) begin errors++; $display("FAIL u2b_acc got=%h want=%h", acc, exp_v); end
  endtask

  task automatic test_signed_8b();
    int lat;
    int low;
    logic [31:0] exp_v;
    launch(8'h80, 8'h80, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 1'b1);
    lat = 0;
    low = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!in_ready) low++;
      if (out_valid) begin lat = c; break; end
    end
    exp_v = q.pop_front();
    checks++; if (lat != 17) begin errors++; $display("FAIL s8b_latency got=%0d want=17", lat); end
    checks++; if (low != 16) begin errors++; $display("FAIL s8b_ready_low got=%0d want=16", low); end
    checks++; if (acc !== exp_v) begin errors++; $display("FAIL s8b_acc got=%h want=%h", acc, exp_v); end
  endtask

  task automatic test_mixed_4b();
    int lat;
    logic [31:0] exp_v;
    launch(8'h08, 8'h0F, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin lat = c; break; end
    end
    exp_v = q.pop_front();
    checks++; if (lat != 5) begin errors++; $display("FAIL mix4b_latency got=%0d want=5", lat); end
    checks++; if (acc !== exp_v) begin errors++; $display("FAIL mix4b_acc got=%h want=%h", acc, exp_v); end
    // upper operand bits must be ignored
    launch(8'hA8, 8'h5F, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin lat = c; break; end
    end
    exp_v = q.pop_front();
    checks++; if (acc !== exp_v || lat != 5) begin errors++; $display("FAIL mix4b_upper_ignored got=%h/%0d want=%h/5", acc, lat, exp_v); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] exp_v;
    launch(8'd3, 8'd3, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin lat = c; break; end
    end
    exp_v = q.pop_front();
    checks++; if (lat == 0 || acc !== exp_v) begin errors++; $display("FAIL b2b_first got=%h/%0d want=%h", acc, lat, exp_v); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got=%b want=1", in_ready); end
    launch(8'd3, 8'd3, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin lat = c; break; end
    end
    exp_v = q.pop_front();
    checks++; if (lat != 2) begin errors++; $display("FAIL b2b_pulse_gap got=%0d want=2", lat); end
    checks++; if (acc !== exp_v) begin errors++; $display("FAIL b2b_second got=%h want=%h", acc, exp_v); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || acc !== exp_v) begin errors++; $display("FAIL b2b_hold got=%b/%h want=0/%h", out_valid, acc, exp_v); end
  endtask

  task automatic test_wrap16();
    int lat;
    logic [31:0] exp_v;
    for (int n = 0; n < 2; n++) begin
      launch(8'hFF, 8'hFF, 1'b0, 1'b0, 2'd3, 2'd3, (n == 0), 1'b1, 1'b1);
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (out_valid16) begin lat = c; break; end
      end
      exp_v = q.pop_front();
      checks++; if (lat != 17 || {16'h0, acc16} !== exp_v) begin errors++; $display("FAIL wrap16_op%0d got=%0d/%0d want=%0d/17", n, acc16, lat, exp_v); end
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    launch(8'hFF, 8'hFF, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    checks++; if (busy !== 1'b1 || acc === 32'd0) begin errors++; $display("FAIL midrun_pre got busy=%b acc=%h want busy=1 acc!=0", busy, acc); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_acc = 0;
    checks++; if (acc !== 32'd0) begin errors++; $display("FAIL midrun_acc got=%h want=0", acc); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrun_flags got ready=%b busy=%b want 1/0", in_ready, busy); end
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrun_no_out_valid got=%0d want=0", seen); end
  endtask

  task automatic test_random();
    int lat;
    int want_lat;
    logic [31:0] exp_v;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [1:0]  pa;
    logic [1:0]  pb;
    for (int n = 0; n < 8; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      pa = 2'($urandom_range(0, 3));
      pb = 2'($urandom_range(0, 3));
      want_lat = (int'(pa) + 1) * (int'(pb) + 1) + 1;
      launch(ra, rb, 1'($urandom), 1'($urandom), pa, pb, (n == 0) | 1'($urandom), 1'b0, 1'b1);
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (out_valid) begin lat = c; break; end
      end
      exp_v = q.pop_front();
      checks++; if (lat != want_lat || acc !== exp_v) begin errors++; $display("FAIL rand%0d got=%h/%0d want=%h/%0d", n, acc, lat, exp_v, want_lat); end
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    model_acc  = 0;
    model16    = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid16 = 1'b0;
    a          = '0;
    b          = '0;
    sign_i     = 1'b0;
    sign_w     = 1'b0;
    prec_a     = '0;
    prec_b     = '0;
    acc_clr    = 1'b0;
    test_reset();
    test_unsigned_2b();
    test_signed_8b();
    test_mixed_4b();
    test_back_to_back();
    test_wrap16();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
